// File: rtl/calc_core_n.sv
// calc_core_n: keypad-driven NDIG-digit BCD sign-magnitude calculator core.
// Keys arrive over a valid/ready handshake. Results are computed serially,
// one BCD digit per cycle, LSD first, after a single magnitude-compare cycle.
module calc_core_n #(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_valid,
    input  logic              tipo,
    input  logic [3:0]        number,
    output logic              key_ready,
    output logic [4*NDIG-1:0] disp_bcd,
    output logic              sign,
    output logic              ovf,
    output logic              busy
);

    localparam int         W      = 4 * NDIG;
    localparam logic [3:0] NDIG_C = 4'(NDIG);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_OP   = 3'd1,
        S_B    = 3'd2,
        S_CALC = 3'd3,
        S_RES  = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    // Shift one BCD digit into the LSD position, dropping the MSD.
    function automatic logic [W-1:0] shift_digit(input logic [W-1:0] m, input logic [3:0] d);
        logic [W-1:0] r;
        r      = m << 3'd4;
        r[3:0] = d;
        return r;
    endfunction

    // Decimal digit add: returns {carry_out, digit}.
    function automatic logic [4:0] bcd_add_digit(input logic [3:0] x, input logic [3:0] y, input logic ci);
        logic [4:0] s;
        s = {1'b0, x} + {1'b0, y} + {4'b0000, ci};
        if (s > 5'd9) begin
            return {1'b1, s[3:0] + 4'd6};
        end else begin
            return {1'b0, s[3:0]};
        end
    endfunction

    // Decimal digit subtract x - y - bi: returns {borrow_out, digit}.
    function automatic logic [4:0] bcd_sub_digit(input logic [3:0] x, input logic [3:0] y, input logic bi);
        logic [4:0] t;
        t = {1'b0, y} + {4'b0000, bi};
        if ({1'b0, x} >= t) begin
            return {1'b0, x - t[3:0]};
        end else begin
            return {1'b1, x + 4'd10 - t[3:0]};
        end
    endfunction

    // Architectural and sequencing registers
    state_t       state_r, state_s;
    logic [W-1:0] ma_r, ma_s;
    logic         sa_r, sa_s;
    logic [W-1:0] mb_r, mb_s;
    logic [3:0]   cnt_r, cnt_s;
    logic         op_r, op_s;          // 0 = add, 1 = sub
    logic         last_r, last_s;
    logic         nop_r, nop_s;        // operator to continue with after a chained calc
    logic         chain_r, chain_s;
    logic         ovf_r, ovf_s;
    logic [3:0]   step_r, step_s;      // 0 = compare cycle, 1..NDIG = digit cycles
    logic         add_mode_r, add_mode_s;
    logic         swap_r, swap_s;      // subtract mb - ma instead of ma - mb
    logic         carry_r, carry_s;
    logic [W-1:0] res_r, res_s;
    logic [W-1:0] disp_r, disp_s;
    logic         sign_r, sign_s;
    logic         busy_r, busy_s;
    logic         key_ready_r, key_ready_s;

    // Key decode and datapath temporaries
    logic         key_fire_s;
    logic         is_digit_s, is_add_s, is_sub_s, is_eq_s, is_clr_s, is_addsub_s;
    logic [3:0]   idx_s;
    logic [3:0]   x_dig_s, y_dig_s;
    logic [4:0]   dig_res_s;
    logic [W-1:0] res_w_s;
    logic         rsign_s;

    assign key_fire_s  = key_valid && key_ready_r;
    assign is_digit_s  = !tipo && (number <= 4'd9);
    assign is_add_s    = tipo && (number == 4'hA);
    assign is_sub_s    = tipo && (number == 4'hB);
    assign is_eq_s     = tipo && (number == 4'hC);
    assign is_clr_s    = tipo && (number == 4'hF);
    assign is_addsub_s = is_add_s || is_sub_s;
    assign idx_s       = step_r - 4'd1;

    // Serial digit datapath: select the current digit pair, add or subtract it, merge into the result
    always_comb begin
        x_dig_s = 4'd0;
        y_dig_s = 4'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_s == 4'(i)) begin
                x_dig_s = swap_r ? mb_r[4*i +: 4] : ma_r[4*i +: 4];
                y_dig_s = swap_r ? ma_r[4*i +: 4] : mb_r[4*i +: 4];
            end else begin
                x_dig_s = x_dig_s;
                y_dig_s = y_dig_s;
            end
        end
        if (add_mode_r) begin
            dig_res_s = bcd_add_digit(x_dig_s, y_dig_s, carry_r);
        end else begin
            dig_res_s = bcd_sub_digit(x_dig_s, y_dig_s, carry_r);
        end
        res_w_s = res_r;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_s == 4'(i)) begin
                res_w_s[4*i +: 4] = dig_res_s[3:0];
            end else begin
                res_w_s = res_w_s;
            end
        end
        if (res_w_s == {W{1'b0}}) begin
            rsign_s = 1'b0;
        end else if (add_mode_r) begin
            rsign_s = sa_r;
        end else if (swap_r) begin
            rsign_s = op_r;
        end else begin
            rsign_s = sa_r;
        end
    end

    // Next-state, register update and output selection
    always_comb begin
        state_s    = state_r;
        ma_s       = ma_r;
        sa_s       = sa_r;
        mb_s       = mb_r;
        cnt_s      = cnt_r;
        op_s       = op_r;
        last_s     = last_r;
        nop_s      = nop_r;
        chain_s    = chain_r;
        ovf_s      = ovf_r;
        step_s     = step_r;
        add_mode_s = add_mode_r;
        swap_s     = swap_r;
        carry_s    = carry_r;
        res_s      = res_r;

        if (key_fire_s && is_clr_s) begin
            state_s = S_A;
            ma_s    = {W{1'b0}};
            sa_s    = 1'b0;
            mb_s    = {W{1'b0}};
            cnt_s   = 4'd0;
            op_s    = 1'b0;
            last_s  = 1'b0;
            nop_s   = 1'b0;
            chain_s = 1'b0;
            ovf_s   = 1'b0;
            step_s  = 4'd0;
        end else begin
            case (state_r)
                S_A: begin
                    if (key_fire_s && is_digit_s) begin
                        if (cnt_r < NDIG_C) begin
                            ma_s = shift_digit(ma_r, number);
                            // leading zeros do not use up a digit position
                            cnt_s = (cnt_r != 4'd0 || number != 4'd0) ? cnt_r + 4'd1 : cnt_r;
                        end else begin
                            ma_s = ma_r;
                        end
                    end else if (key_fire_s && is_addsub_s) begin
                        op_s    = is_sub_s;
                        state_s = S_OP;
                    end else begin
                        state_s = S_A;
                    end
                end
                S_OP: begin
                    if (key_fire_s && is_digit_s) begin
                        mb_s       = {W{1'b0}};
                        mb_s[3:0]  = number;
                        cnt_s      = (number != 4'd0) ? 4'd1 : 4'd0;
                        state_s    = S_B;
                    end else if (key_fire_s && is_addsub_s) begin
                        op_s = is_sub_s;
                    end else begin
                        state_s = S_OP;
                    end
                end
                S_B: begin
                    if (key_fire_s && is_digit_s) begin
                        if (cnt_r < NDIG_C) begin
                            mb_s  = shift_digit(mb_r, number);
                            cnt_s = (cnt_r != 4'd0 || number != 4'd0) ? cnt_r + 4'd1 : cnt_r;
                        end else begin
                            mb_s = mb_r;
                        end
                    end else if (key_fire_s && (is_addsub_s || is_eq_s)) begin
                        nop_s   = is_sub_s;
                        chain_s = is_addsub_s;
                        step_s  = 4'd0;
                        carry_s = 1'b0;
                        res_s   = {W{1'b0}};
                        state_s = S_CALC;
                    end else begin
                        state_s = S_B;
                    end
                end
                S_CALC: begin
                    if (step_r == 4'd0) begin
                        add_mode_s = (sa_r == op_r);
                        swap_s     = (ma_r < mb_r);
                        carry_s    = 1'b0;
                        step_s     = 4'd1;
                    end else begin
                        res_s   = res_w_s;
                        carry_s = dig_res_s[4];
                        if (step_r == NDIG_C) begin
                            ma_s   = res_w_s;
                            sa_s   = rsign_s;
                            last_s = op_r;
                            step_s = 4'd0;
                            if (add_mode_r && dig_res_s[4]) begin
                                ovf_s   = 1'b1;
                                state_s = S_ERR;
                            end else if (chain_r) begin
                                op_s    = nop_r;
                                state_s = S_OP;
                            end else begin
                                state_s = S_RES;
                            end
                        end else begin
                            step_s = step_r + 4'd1;
                        end
                    end
                end
                S_RES: begin
                    if (key_fire_s && is_digit_s) begin
                        ma_s      = {W{1'b0}};
                        ma_s[3:0] = number;
                        sa_s      = 1'b0;
                        cnt_s     = (number != 4'd0) ? 4'd1 : 4'd0;
                        state_s   = S_A;
                    end else if (key_fire_s && is_addsub_s) begin
                        op_s    = is_sub_s;
                        state_s = S_OP;
                    end else if (key_fire_s && is_eq_s) begin
                        // repeat the previous operation with the unchanged entry
                        op_s    = last_r;
                        chain_s = 1'b0;
                        step_s  = 4'd0;
                        carry_s = 1'b0;
                        res_s   = {W{1'b0}};
                        state_s = S_CALC;
                    end else begin
                        state_s = S_RES;
                    end
                end
                S_ERR: begin
                    state_s = S_ERR;
                end
                default: begin
                    state_s = S_A;
                end
            endcase
        end

        if (state_s == S_B || state_s == S_CALC) begin
            disp_s = mb_s;
            sign_s = 1'b0;
        end else begin
            disp_s = ma_s;
            sign_s = sa_s;
        end
        busy_s      = (state_s == S_CALC);
        key_ready_s = (state_s != S_CALC);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_A;
            ma_r        <= {W{1'b0}};
            sa_r        <= 1'b0;
            mb_r        <= {W{1'b0}};
            cnt_r       <= 4'd0;
            op_r        <= 1'b0;
            last_r      <= 1'b0;
            nop_r       <= 1'b0;
            chain_r     <= 1'b0;
            ovf_r       <= 1'b0;
            step_r      <= 4'd0;
            add_mode_r  <= 1'b0;
            swap_r      <= 1'b0;
            carry_r     <= 1'b0;
            res_r       <= {W{1'b0}};
            disp_r      <= {W{1'b0}};
            sign_r      <= 1'b0;
            busy_r      <= 1'b0;
            key_ready_r <= 1'b1;
        end else begin
            state_r     <= state_s;
            ma_r        <= ma_s;
            sa_r        <= sa_s;
            mb_r        <= mb_s;
            cnt_r       <= cnt_s;
            op_r        <= op_s;
            last_r      <= last_s;
            nop_r       <= nop_s;
            chain_r     <= chain_s;
            ovf_r       <= ovf_s;
            step_r      <= step_s;
            add_mode_r  <= add_mode_s;
            swap_r      <= swap_s;
            carry_r     <= carry_s;
            res_r       <= res_s;
            disp_r      <= disp_s;
            sign_r      <= sign_s;
            busy_r      <= busy_s;
            key_ready_r <= key_ready_s;
        end
    end

    assign key_ready = key_ready_r;
    assign disp_bcd  = disp_r;
    assign sign      = sign_r;
    assign ovf       = ovf_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_calc_core_n.sv
// tb_calc_core_n: table-driven key sequences against calc_core_n (NDIG=4),
// plus hand-written multi-cycle sequences and an NDIG=6 instance.
module tb_calc_core_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        kv4, tipo4, rdy4, sign4, ovf4, busy4;
    logic [3:0]  num4;
    logic [15:0] disp4;
    logic        kv6, tipo6, rdy6, sign6, ovf6, busy6;
    logic [3:0]  num6;
    logic [23:0] disp6;

    calc_core_n #(.NDIG(4)) dut4 (
        .clk(clk), .reset(reset), .key_valid(kv4), .tipo(tipo4), .number(num4),
        .key_ready(rdy4), .disp_bcd(disp4), .sign(sign4), .ovf(ovf4), .busy(busy4)
    );

    calc_core_n #(.NDIG(6)) dut6 (
        .clk(clk), .reset(reset), .key_valid(kv6), .tipo(tipo6), .number(num6),
        .key_ready(rdy6), .disp_bcd(disp6), .sign(sign6), .ovf(ovf6), .busy(busy6)
    );

    localparam logic [4:0] K_ADD = 5'h1A;
    localparam logic [4:0] K_SUB = 5'h1B;
    localparam logic [4:0] K_EQ  = 5'h1C;
    localparam logic [4:0] K_CLR = 5'h1F;
    localparam logic [4:0] K_PAD = 5'h00;

    typedef struct {
        logic [39:0] keys;
        int          nk;
        logic [15:0] disp;
        logic        sgn;
        logic        ov;
        int          bcy;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    int errors = 0;
    int checks = 0;
    int n;

    function automatic logic [39:0] ks(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                                       input logic [4:0] d, input logic [4:0] e, input logic [4:0] f,
                                       input logic [4:0] g, input logic [4:0] h);
        return {h, g, f, e, d, c, b, a};
    endfunction

    task automatic set_vec(input int i, input logic [39:0] k, input int nk, input logic [15:0] d,
                           input logic s, input logic o, input int b);
        vecs[i].keys = k;
        vecs[i].nk   = nk;
        vecs[i].disp = d;
        vecs[i].sgn  = s;
        vecs[i].ov   = o;
        vecs[i].bcy  = b;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Present one key at a negedge and return at the negedge after it is consumed
    task automatic press(input logic sel, input logic [4:0] k);
        int g;
        g = 0;
        while (((sel ? rdy6 : rdy4) !== 1'b1) && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: key_ready stayed low for %0d cycles", g);
        end
        if (sel) begin
            kv6 = 1'b1;
            {tipo6, num6} = k;
        end else begin
            kv4 = 1'b1;
            {tipo4, num4} = k;
        end
        @(negedge clk);
        kv4 = 1'b0;
        kv6 = 1'b0;
    endtask

    task automatic wait_idle(input logic sel, output int cyc);
        cyc = 0;
        while (((sel ? busy6 : busy4) === 1'b1) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        kv4 = 1'b0; tipo4 = 1'b0; num4 = 4'd0;
        kv6 = 1'b0; tipo6 = 1'b0; num6 = 4'd0;

        set_vec(0,  ks(5'h01, 5'h02, K_ADD, 5'h07, K_EQ, K_PAD, K_PAD, K_PAD), 5, 16'h0019, 1'b0, 1'b0, 5);
        set_vec(1,  ks(5'h05, K_SUB, 5'h08, K_EQ, K_PAD, K_PAD, K_PAD, K_PAD), 4, 16'h0003, 1'b1, 1'b0, 5);
        set_vec(2,  ks(5'h09, 5'h09, 5'h09, 5'h09, K_ADD, 5'h01, K_EQ, K_PAD), 7, 16'h0000, 1'b0, 1'b1, 5);
        set_vec(3,  ks(5'h03, K_ADD, 5'h04, K_SUB, 5'h02, K_EQ, K_PAD, K_PAD), 6, 16'h0005, 1'b0, 1'b0, 5);
        set_vec(4,  ks(5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, K_PAD, K_PAD), 6, 16'h1234, 1'b0, 1'b0, 0);
        set_vec(5,  ks(5'h02, 5'h00, K_SUB, 5'h05, 5'h00, K_EQ, K_PAD, K_PAD), 6, 16'h0030, 1'b1, 1'b0, 5);
        set_vec(6,  ks(5'h04, 5'h05, K_ADD, 5'h05, 5'h05, K_EQ, K_PAD, K_PAD), 6, 16'h0100, 1'b0, 1'b0, 5);
        set_vec(7,  ks(K_SUB, 5'h05, K_EQ, K_ADD, 5'h05, K_EQ, K_PAD, K_PAD), 6, 16'h0000, 1'b0, 1'b0, 5);
        set_vec(8,  ks(5'h01, 5'h0C, 5'h1D, K_EQ, 5'h02, K_PAD, K_PAD, K_PAD), 5, 16'h0012, 1'b0, 1'b0, 0);
        set_vec(9,  ks(5'h07, 5'h00, 5'h01, K_SUB, 5'h09, K_EQ, K_PAD, K_PAD), 6, 16'h0692, 1'b0, 1'b0, 5);
        set_vec(10, ks(5'h08, K_ADD, K_SUB, 5'h03, K_EQ, K_PAD, K_PAD, K_PAD), 5, 16'h0005, 1'b0, 1'b0, 5);
        set_vec(11, ks(5'h01, K_ADD, 5'h01, K_EQ, 5'h04, K_PAD, K_PAD, K_PAD), 5, 16'h0004, 1'b0, 1'b0, 0);
        set_vec(12, ks(5'h02, K_ADD, 5'h03, K_EQ, K_ADD, 5'h04, K_EQ, K_PAD), 7, 16'h0009, 1'b0, 1'b0, 5);
        set_vec(13, ks(5'h05, K_SUB, 5'h09, K_SUB, 5'h09, K_EQ, K_PAD, K_PAD), 6, 16'h0013, 1'b1, 1'b0, 5);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_disp", {16'd0, disp4}, 32'h0);
        check("rst_sign", {31'd0, sign4}, 32'h0);
        check("rst_ovf", {31'd0, ovf4}, 32'h0);
        check("rst_busy", {31'd0, busy4}, 32'h0);
        check("rst_ready", {31'd0, rdy4}, 32'h1);
        check("rst_disp6", {8'd0, disp6}, 32'h0);

        // key coinciding with reset is dropped
        reset = 1'b1;
        kv4 = 1'b1;
        {tipo4, num4} = 5'h07;
        @(negedge clk);
        reset = 1'b0;
        kv4 = 1'b0;
        check("rst_key_drop", {16'd0, disp4}, 32'h0);
        press(1'b0, 5'h07);
        check("key_after_rst", {16'd0, disp4}, 32'h7);

        for (int i = 0; i < NV; i++) begin
            do_reset();
            for (int k = 0; k < vecs[i].nk; k++) begin
                press(1'b0, vecs[i].keys[5*k +: 5]);
            end
            wait_idle(1'b0, n);
            check($sformatf("v%0d_busy_cycles", i), n, vecs[i].bcy);
            check($sformatf("v%0d_disp", i), {16'd0, disp4}, {16'd0, vecs[i].disp});
            check($sformatf("v%0d_sign", i), {31'd0, sign4}, {31'd0, vecs[i].sgn});
            check($sformatf("v%0d_ovf", i), {31'd0, ovf4}, {31'd0, vecs[i].ov});
            check($sformatf("v%0d_ready", i), {31'd0, rdy4}, 32'h1);
        end

        // repeat-equals reuses last=sub and mb=8: -3 - 8 = -11
        do_reset();
        press(1'b0, 5'h05); press(1'b0, K_SUB); press(1'b0, 5'h08); press(1'b0, K_EQ);
        wait_idle(1'b0, n);
        press(1'b0, K_EQ);
        wait_idle(1'b0, n);
        check("rep_busy_cycles", n, 5);
        check("rep_disp", {16'd0, disp4}, 32'h0011);
        check("rep_sign", {31'd0, sign4}, 32'h1);

        // overflow locks out everything but clear
        do_reset();
        press(1'b0, 5'h09); press(1'b0, 5'h09); press(1'b0, 5'h09); press(1'b0, 5'h09);
        press(1'b0, K_ADD); press(1'b0, 5'h01); press(1'b0, K_EQ);
        wait_idle(1'b0, n);
        press(1'b0, 5'h04);
        press(1'b0, K_ADD);
        check("err_disp", {16'd0, disp4}, 32'h0);
        check("err_ovf", {31'd0, ovf4}, 32'h1);
        press(1'b0, K_CLR);
        check("clr_ovf", {31'd0, ovf4}, 32'h0);
        check("clr_disp", {16'd0, disp4}, 32'h0);
        press(1'b0, 5'h03); press(1'b0, 5'h04);
        check("clr_entry", {16'd0, disp4}, 32'h0034);

        // chained add shows intermediate result in S_OP
        do_reset();
        press(1'b0, 5'h03); press(1'b0, K_ADD); press(1'b0, 5'h04); press(1'b0, K_SUB);
        wait_idle(1'b0, n);
        check("chain_mid_disp", {16'd0, disp4}, 32'h0007);

        // key held through busy is consumed once, when ready returns
        do_reset();
        press(1'b0, 5'h01); press(1'b0, K_ADD); press(1'b0, 5'h02); press(1'b0, K_EQ);
        kv4 = 1'b1;
        {tipo4, num4} = 5'h09;
        n = 0;
        while (rdy4 !== 1'b1 && n < 50) begin
            check("ready_vs_busy", {31'd0, rdy4}, {31'd0, ~busy4});
            @(negedge clk);
            n++;
        end
        check("hold_wait_cycles", n, 5);
        check("hold_result", {16'd0, disp4}, 32'h0003);
        @(negedge clk);
        kv4 = 1'b0;
        check("hold_consumed", {16'd0, disp4}, 32'h0009);
        @(negedge clk);
        check("hold_once", {16'd0, disp4}, 32'h0009);

        // reset during the third busy cycle discards the calculation
        do_reset();
        press(1'b0, 5'h06); press(1'b0, K_ADD); press(1'b0, 5'h07); press(1'b0, K_EQ);
        @(negedge clk);
        @(negedge clk);
        check("midcalc_busy", {31'd0, busy4}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", {31'd0, busy4}, 32'h0);
        check("midrst_disp", {16'd0, disp4}, 32'h0);
        check("midrst_sign", {31'd0, sign4}, 32'h0);
        check("midrst_ovf", {31'd0, ovf4}, 32'h0);
        check("midrst_ready", {31'd0, rdy4}, 32'h1);
        repeat (3) @(negedge clk);
        check("midrst_stays", {16'd0, disp4}, 32'h0);

        // NDIG=6 instance
        do_reset();
        press(1'b1, 5'h01); press(1'b1, 5'h02); press(1'b1, K_ADD); press(1'b1, 5'h07); press(1'b1, K_EQ);
        wait_idle(1'b1, n);
        check("n6_busy_cycles", n, 7);
        check("n6_disp", {8'd0, disp6}, 32'h000019);
        check("n6_sign", {31'd0, sign6}, 32'h0);
        check("n6_ovf", {31'd0, ovf6}, 32'h0);
        do_reset();
        press(1'b1, 5'h01); press(1'b1, 5'h02); press(1'b1, 5'h03); press(1'b1, 5'h04); press(1'b1, 5'h05);
        check("n6_entry", {8'd0, disp6}, 32'h012345);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
